peak_sweep_scheduler: RTL and testbench
=======================================

PEAK_SWEEP_SCHEDULER -- requirements
Module: peak_sweep_scheduler

Interface
REQ-001 The block SHALL have parameter OCT, default 5, giving the number of octaves swept.
REQ-002 The block SHALL have parameter SLOTS, default 12, giving the number of note slots per octave.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-005 The block SHALL have port start, input, 1, requests a new sweep; honoured only in IDLE.
REQ-006 The block SHALL have port abort, input, 1, cancels a sweep in progress.
REQ-007 The block SHALL have port peakHere, input, 1, the active slot contains a detected peak.
REQ-008 The block SHALL have port divDone, input, 1, the shared divider has finished its current operation.
REQ-009 The block SHALL have port divStart, output, 1, one-cycle pulse that launches a divider operation.
REQ-010 The block SHALL have port divSel, output, 1, divider owner: 0 = peak placer, 1 = peak merger.
REQ-011 The block SHALL have port writeEn, output, 1, one-cycle peak-register write strobe for the active slot.
REQ-012 The block SHALL have port clearIntermediate, output, 1, clears the peak registers at sweep start.
REQ-013 The block SHALL have port finished, output, 1, one-cycle pulse marking sweep completion.
REQ-014 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 The block SHALL have port activeSlot, output, $clog2(SLOTS), the current note slot.
REQ-016 The block SHALL have port activeOctave, output, $clog2(OCT), the current octave.

Function
REQ-017 The states SHALL be IDLE, PLACE_ISSUE, PLACE_WAIT, MERGE_ISSUE, MERGE_WAIT, WRITE and DONE.
REQ-018 In IDLE with start=1, the block SHALL assert clearIntermediate combinationally in that cycle and enter PLACE_ISSUE on the next edge with slot=0, octave=0.
REQ-019 In PLACE_ISSUE, divStart SHALL be 1 and divSel SHALL be 0 for exactly one cycle, then the state SHALL be PLACE_WAIT.
REQ-020 In PLACE_WAIT, divDone=1 SHALL move the state to MERGE_ISSUE; otherwise the state SHALL hold indefinitely.
REQ-021 MERGE_ISSUE and MERGE_WAIT SHALL mirror PLACE_ISSUE and PLACE_WAIT with divSel=1; divDone in MERGE_WAIT SHALL move the state to WRITE.
REQ-022 In WRITE, writeEn SHALL be 1 for one cycle, then the block SHALL advance.
REQ-023 Advance SHALL work as follows:
- If slot=SLOTS-1 and octave=OCT-1, go to DONE.
- Else if slot=SLOTS-1, set slot to 0, increment octave, and go to PLACE_ISSUE.
- Else increment slot and go to PLACE_ISSUE.
REQ-024 In DONE, finished SHALL be 1 for one cycle; the next state SHALL be IDLE, with slot and octave cleared to 0.
REQ-025 divSel SHALL hold its last value outside the ISSUE and WAIT states.
REQ-026 divDone SHALL be ignored outside the WAIT states, including when it coincides with divStart.
REQ-027 start SHALL be ignored while busy=1.
REQ-028 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with slot and octave cleared, no finished pulse and no writeEn pulse.
REQ-029 If abort and start are both 1 in IDLE, start SHALL win.
REQ-030 With divDone tied high, each slot SHALL take exactly 5 cycles.

Reset
REQ-031 While rst=1, the state SHALL be IDLE and every output SHALL be 0, regardless of clk.
REQ-032 Reset asserted mid-sweep SHALL abandon the sweep with no finished pulse.
REQ-033 After rst falls, the block SHALL accept start on the first rising edge.

Configuration
REQ-034 With SWEEP_SKIP_EMPTY_EN defined, PLACE_ISSUE with peakHere=0 SHALL assert no divStart and no writeEn and SHALL advance directly per REQ-023, so an empty slot costs 1 cycle.
REQ-035 Without SWEEP_SKIP_EMPTY_EN, every slot SHALL run the full 5-state sequence regardless of peakHere, and peakHere SHALL be unused.

Verification
REQ-036 Scenario: start pulse at cycle 0, divDone tied high, all peaks present.
- clearIntermediate=1 at cycle 0.
- Exactly 60 writeEn pulses and 120 divStart pulses, alternating divSel 0,1.
- finished=1 at cycle 301.
REQ-037 Scenario: SWEEP_SKIP_EMPTY_EN defined, peakHere=0 throughout, start at cycle 0.
- No divStart and no writeEn.
- activeSlot/activeOctave step once per cycle.
- finished=1 at cycle 61.
REQ-038 Scenario: divDone delayed 7 cycles after each divStart.
- Each WAIT state holds for 7 cycles.
- Each slot takes 17 cycles.
- activeSlot is unchanged while waiting.
REQ-039 Scenario: wrap at slot 11.
- After slot 11 of octave 0, the next PLACE_ISSUE shows slot=0, octave=1.
- After slot 11 of octave 4, the state goes to DONE and outputs return to 0.
REQ-040 Scenario: abort in MERGE_WAIT at octave 2, slot 5.
- Next cycle: busy=0, slot=0, octave=0, no finished pulse.
- A subsequent start restarts at slot 0, octave 0.
REQ-041 Scenario: rst asserted between clock edges mid-sweep.
- All outputs go to 0 immediately.
- A start applied while busy would be ignored; after reset, start is accepted normally.

Source files
------------

// File: rtl/peak_sweep_scheduler_if.sv
// Handshake bundle between the peak sweep scheduler and its surroundings
// (stimulus side = master, scheduler = slave).
interface peak_sweep_scheduler_if #(
  parameter int unsigned OCT   = 5,
  parameter int unsigned SLOTS = 12
);
  localparam int unsigned SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned OW = (OCT > 1) ? $clog2(OCT) : 1;

  logic          start;
  logic          abort;
  logic          peakHere;
  logic          divDone;
  logic          divStart;
  logic          divSel;
  logic          writeEn;
  logic          clearIntermediate;
  logic          finished;
  logic          busy;
  logic [SW-1:0] activeSlot;
  logic [OW-1:0] activeOctave;

  modport master (
    output start, abort, peakHere, divDone,
    input  divStart, divSel, writeEn, clearIntermediate, finished, busy,
           activeSlot, activeOctave
  );

  modport slave (
    input  start, abort, peakHere, divDone,
    output divStart, divSel, writeEn, clearIntermediate, finished, busy,
           activeSlot, activeOctave
  );
endinterface

// File: rtl/peak_sweep_scheduler.sv
// Sweeps OCT x SLOTS note slots, sequencing place/merge divider jobs and a peak write per slot.
// Optional macro SWEEP_SKIP_EMPTY_EN: slots without a peak are skipped in one cycle.
module peak_sweep_scheduler #(
  parameter int unsigned OCT   = 5,
  parameter int unsigned SLOTS = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  peak_sweep_scheduler_if.slave  bus
);
  localparam int unsigned SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned OW = (OCT > 1) ? $clog2(OCT) : 1;
  localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);
  localparam logic [OW-1:0] LAST_OCT  = OW'(OCT - 1);

  typedef enum logic [2:0] {
    IDLE, PLACE_ISSUE, PLACE_WAIT, MERGE_ISSUE, MERGE_WAIT, WRITE, DONE
  } state_e;

  state_e        state_q, state_d, adv_state;
  logic [SW-1:0] slot_q, slot_d, adv_slot;
  logic [OW-1:0] oct_q, oct_d, adv_oct;
  logic          sel_q, sel_d;
  logic          skip_slot;

`ifdef SWEEP_SKIP_EMPTY_EN
  assign skip_slot = (state_q == PLACE_ISSUE) && !bus.peakHere;
`else
  assign skip_slot = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      slot_q  <= '0;
      oct_q   <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      oct_q   <= oct_d;
      sel_q   <= sel_d;
    end
  end

  // Where a finished slot leads: next slot, octave wrap, or DONE holding the last position.
  always_comb begin
    adv_state = PLACE_ISSUE;
    adv_slot  = slot_q + 1'b1;
    adv_oct   = oct_q;
    if (slot_q == LAST_SLOT) begin
      adv_slot = '0;
      if (oct_q == LAST_OCT) begin
        adv_state = DONE;
        adv_slot  = slot_q;
      end else begin
        adv_oct = oct_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    oct_d   = oct_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = PLACE_ISSUE;
        slot_d  = '0;
        oct_d   = '0;
      end
      PLACE_ISSUE: begin
        if (skip_slot) begin
          state_d = adv_state;
          slot_d  = adv_slot;
          oct_d   = adv_oct;
        end else begin
          state_d = PLACE_WAIT;
        end
      end
      PLACE_WAIT:  if (bus.divDone) state_d = MERGE_ISSUE;
      MERGE_ISSUE: state_d = MERGE_WAIT;
      MERGE_WAIT:  if (bus.divDone) state_d = WRITE;
      WRITE: begin
        state_d = adv_state;
        slot_d  = adv_slot;
        oct_d   = adv_oct;
      end
      DONE: begin
        state_d = IDLE;
        slot_d  = '0;
        oct_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    if (bus.abort && state_q != IDLE) begin
      state_d = IDLE;
      slot_d  = '0;
      oct_d   = '0;
    end
  end

  // Strobes are suppressed in an aborted cycle; divSel keeps its last owner outside ISSUE/WAIT.
  always_comb begin
    bus.busy              = (state_q != IDLE);
    bus.clearIntermediate = (state_q == IDLE) && bus.start && !rst;
    bus.divStart          = (((state_q == PLACE_ISSUE) && !skip_slot) ||
                             (state_q == MERGE_ISSUE)) && !bus.abort;
    bus.writeEn           = (state_q == WRITE) && !bus.abort;
    bus.finished          = (state_q == DONE) && !bus.abort;
    bus.activeSlot        = slot_q;
    bus.activeOctave      = oct_q;
    case (state_q)
      PLACE_ISSUE, PLACE_WAIT: sel_d = 1'b0;
      MERGE_ISSUE, MERGE_WAIT: sel_d = 1'b1;
      default:                 sel_d = sel_q;
    endcase
    bus.divSel = sel_d;
  end
endmodule

// File: tb/tb_peak_sweep_scheduler.sv
// Self-checking bench for peak_sweep_scheduler: slot-index reference model plus directed scenarios.
module tb_peak_sweep_scheduler;
  localparam int unsigned OCT   = 5;
  localparam int unsigned SLOTS = 12;
  localparam int unsigned SW    = $clog2(SLOTS);
  localparam int unsigned OW    = $clog2(OCT);
  localparam int unsigned VW    = 6 + SW + OW;
`ifdef SWEEP_SKIP_EMPTY_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  int   dd_mode  = 0;   // 0 tied high, 1 fixed delay after divStart, 2 random
  int   dd_delay = 7;

  peak_sweep_scheduler_if #(.OCT(OCT), .SLOTS(SLOTS)) bus ();

  peak_sweep_scheduler #(.OCT(OCT), .SLOTS(SLOTS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a linear slot index n and a phase within the slot
  // (0 place issue, 1 place wait, 2 merge issue, 3 merge wait, 4 write, 5 done).
  bit m_active = 1'b0;
  int m_n      = 0;
  int m_ph     = 0;
  bit m_sel    = 1'b0;

  always @(negedge clk) begin : model
    logic [VW-1:0] e, a;
    bit sel, sk, ds, we, fin;
    a = {bus.busy, bus.clearIntermediate, bus.divStart, bus.divSel, bus.writeEn,
         bus.finished, bus.activeSlot, bus.activeOctave};
    if (rst) begin
      e = '0;
      m_active = 1'b0; m_n = 0; m_ph = 0; m_sel = 1'b0;
    end else if (!m_active) begin
      e = {1'b0, bus.start, 1'b0, m_sel, 1'b0, 1'b0, SW'(0), OW'(0)};
      if (bus.start) begin
        m_active = 1'b1; m_n = 0; m_ph = 0;
      end
    end else begin
      sel = (m_ph < 2) ? 1'b0 : (m_ph < 4) ? 1'b1 : m_sel;
      sk  = SKIP && (m_ph == 0) && !bus.peakHere;
      ds  = (((m_ph == 0) && !sk) || (m_ph == 2)) && !bus.abort;
      we  = (m_ph == 4) && !bus.abort;
      fin = (m_ph == 5) && !bus.abort;
      e = {1'b1, 1'b0, ds, sel, we, fin, SW'(m_n % SLOTS), OW'(m_n / SLOTS)};
      m_sel = sel;
      if (bus.abort) begin
        m_active = 1'b0; m_n = 0; m_ph = 0;
      end else if (m_ph == 5) begin
        m_active = 1'b0; m_n = 0; m_ph = 0;
      end else if ((m_ph == 0 && sk) || m_ph == 4) begin
        if (m_n == OCT * SLOTS - 1) m_ph = 5;
        else begin m_n++; m_ph = 0; end
      end else if (m_ph == 1 || m_ph == 3) begin
        if (bus.divDone) m_ph++;
      end else begin
        m_ph++;
      end
    end
    chk("outputs{busy,clr,dStart,dSel,wEn,fin,slot,oct}", a, e);
  end

  // Divider stand-in: answers each divStart after dd_delay cycles, or tied high, or random.
  initial begin : divider
    bit saw, pend;
    int cnt;
    pend = 1'b0; cnt = 0;
    bus.divDone = 1'b0;
    forever begin
      @(negedge clk);
      saw = bus.divStart;
      @(posedge clk); #1;
      if (saw) begin pend = 1'b1; cnt = dd_delay - 1; end
      else if (pend && cnt > 0) cnt--;
      case (dd_mode)
        0: bus.divDone = 1'b1;
        1: begin
          bus.divDone = pend && (cnt == 0);
          if (bus.divDone) pend = 1'b0;
        end
        default: bus.divDone = ($urandom_range(0, 2) == 0);
      endcase
    end
  end

  task automatic run_sweep(input bit pk, input int mode, input int exp_fin, input int exp_ds0,
                           input int exp_ds1, input int exp_we, input int exp_slot1);
    int nds0, nds1, nwe, fin, s1;
    nds0 = 0; nds1 = 0; nwe = 0; fin = -1; s1 = -1;
    dd_mode = mode;
    @(posedge clk); #1;
    bus.peakHere = pk;
    bus.start = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (c == 0) chk("clear_at_start", bus.clearIntermediate, 1);
      if (bus.divStart && !bus.divSel) nds0++;
      if (bus.divStart && bus.divSel)  nds1++;
      if (bus.writeEn) nwe++;
      if (s1 < 0 && bus.busy && bus.activeSlot == 1) s1 = c;
      if (bus.finished) begin fin = c; break; end
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    bus.start = 1'b0;
    chk("finished_cycle", fin, exp_fin);
    chk("divStart_place_count", nds0, exp_ds0);
    chk("divStart_merge_count", nds1, exp_ds1);
    chk("writeEn_count", nwe, exp_we);
    chk("slot1_first_cycle", s1, exp_slot1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_after_done", {bus.busy, bus.activeSlot, bus.activeOctave}, 0);
  endtask

  initial begin : stim
    bit found;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.peakHere = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {bus.busy, bus.divStart, bus.writeEn, bus.finished,
                          bus.clearIntermediate, bus.divSel, bus.activeSlot, bus.activeOctave}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_sweep(1'b1, 0, 301, 60, 60, 60, 6);
`ifdef SWEEP_SKIP_EMPTY_EN
    run_sweep(1'b0, 0, 61, 0, 0, 0, 2);
`else
    run_sweep(1'b0, 0, 301, 60, 60, 60, 6);
`endif
    run_sweep(1'b1, 1, 1021, 60, 60, 60, 18);

    // Abort in MERGE_WAIT at octave 2, slot 5.
    dd_mode = 1;
    bus.peakHere = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (bus.busy && bus.activeOctave == 2 && bus.activeSlot == 5 && bus.divSel &&
          !bus.divStart && !bus.writeEn) begin
        found = 1'b1;
        break;
      end
    end
    chk("abort_target_reached", found, 1);
    @(posedge clk); #1;
    bus.abort = 1'b1;
    @(negedge clk);
    chk("abort_cycle_no_finish", {bus.finished, bus.writeEn}, 0);
    @(posedge clk); #1;
    bus.abort = 1'b0;
    @(negedge clk);
    chk("after_abort", {bus.busy, bus.finished, bus.activeSlot, bus.activeOctave}, 0);
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("restart_after_abort", {bus.busy, bus.divStart, bus.activeSlot, bus.activeOctave},
        {1'b1, 1'b1, SW'(0), OW'(0)});

    // Asynchronous reset landing between clock edges mid-sweep.
    repeat (40) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", {bus.busy, bus.divStart, bus.writeEn, bus.finished,
                                bus.clearIntermediate, bus.divSel, bus.activeSlot, bus.activeOctave}, 0);
    bus.start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("start_after_reset", {bus.busy, bus.activeSlot, bus.activeOctave},
        {1'b1, SW'(0), OW'(0)});
    @(posedge clk); #1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;

    // Randomised traffic against the model.
    dd_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      bus.start    = ($urandom_range(0, 7) == 0);
      bus.abort    = ($urandom_range(0, 149) == 0);
      bus.peakHere = $urandom_range(0, 1) != 0;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "time limit");
  end
endmodule
